// File: rtl/shift_tx_pkg.sv
`default_nettype none
// ============================================================================
// shift_tx_pkg : shared state encoding and sizing helpers for shift_tx
// Rev 1.0
// ============================================================================
package shift_tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    // Width of a counter that must hold 0..n-1
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int div_width(input int clk_div);
        return $clog2(clk_div + 1);
    endfunction

    // Clock edges from accept to the done pulse
    function automatic int xfer_cycles(input int width, input int clk_div);
        return (2 * width + 1) * clk_div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_tick_gen.sv
`default_nettype none
// ============================================================================
// shift_tick_gen : CLK_DIV divider, tick on the terminal count, held in clear
// Rev 1.0
// ============================================================================
module shift_tick_gen
    import shift_tx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = div_width(CLK_DIV);
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == TERM);

endmodule
`default_nettype wire

// File: rtl/shift_tx.sv
`default_nettype none
// ============================================================================
// shift_tx : MSB-first serializer driving a serial-in/parallel-out register
// Rev 1.0
// ============================================================================
module shift_tx
    import shift_tx_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             sr_reset,
    output logic             done
);

    localparam int            BW       = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic             tick;
    logic             accept;
    logic             last_bit;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign last_bit = (bit_cnt == LAST_BIT);
    // The MSB of the shift register is the line itself, so sdata moves only
    // at load and at the shift that accompanies each sclk fall.
    assign sdata    = shreg[WIDTH-1];

    shift_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(in_ready),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (accept) next_state = SHIFT_LO;
            SHIFT_LO: if (tick)   next_state = SHIFT_HI;
            SHIFT_HI: if (tick)   next_state = last_bit ? LATCH : SHIFT_LO;
            LATCH:    if (tick)   next_state = IDLE;
            default:              next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            latch   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= in_data;
                        bit_cnt <= '0;
                    end
                end
                SHIFT_LO: begin
                    if (tick) sclk <= 1'b1;
                end
                SHIFT_HI: begin
                    if (tick) begin
                        sclk <= 1'b0;
                        if (last_bit) begin
                            latch <= 1'b1;
                        end else begin
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        latch <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Downstream reset follows reset asynchronously, releases on the next edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_reset <= 1'b1;
        end else begin
            sr_reset <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_tx.sv
`default_nettype none
// ============================================================================
// tb_shift_tx : scoreboard bench, DUT 0 at CLK_DIV=2 and DUT 1 at CLK_DIV=1
// Rev 1.0
// ============================================================================
module tb_shift_tx;
    import shift_tx_pkg::*;

    localparam int W     = 8;
    localparam int DIV_A = 2;
    localparam int DIV_B = 1;

    typedef struct {
        int           dut;
        logic [W-1:0] word;
    } exp_t;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_data  [2];
    logic         in_valid [2];
    logic         in_ready [2];
    logic         sclk     [2];
    logic         sdata    [2];
    logic         latch    [2];
    logic         sr_reset [2];
    logic         done     [2];

    shift_tx #(.WIDTH(W), .CLK_DIV(DIV_A)) u_dut_a (
        .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .sclk(sclk[0]), .sdata(sdata[0]), .latch(latch[0]),
        .sr_reset(sr_reset[0]), .done(done[0])
    );

    shift_tx #(.WIDTH(W), .CLK_DIV(DIV_B)) u_dut_b (
        .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .sclk(sclk[1]), .sdata(sdata[1]), .latch(latch[1]),
        .sr_reset(sr_reset[1]), .done(done[1])
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];

    int           acc       [2];
    int           rises     [2];
    int           done_cnt  [2];
    int           last_done [2];
    int           last_gap  [2];
    logic [W-1:0] ds_sr     [2];
    logic [W-1:0] ds_do     [2];
    bit           busy      [2];
    bit           tim_bad   [2];
    bit           rdy_bad   [2];
    bit           prev_sclk [2];
    bit           prev_latch[2];
    bit           prev_done [2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor plus downstream SIPO register model, sampled on the falling edge
    always @(negedge clk) begin : monitor
        int   div;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            div = (k == 0) ? DIV_A : DIV_B;
            if (sclk[k] && !prev_sclk[k]) begin
                if (cyc != acc[k] + (2 * rises[k] + 1) * div) tim_bad[k] = 1'b1;
                rises[k]++;
                if (!sr_reset[k]) ds_sr[k] = {ds_sr[k][W-2:0], sdata[k]};
            end
            if (latch[k] && !prev_latch[k]) begin
                if (cyc != acc[k] + 2 * W * div) tim_bad[k] = 1'b1;
                ds_do[k] = ds_sr[k];
            end
            if (sr_reset[k]) begin
                ds_sr[k] = '0;
                ds_do[k] = '0;
                busy[k]  = 1'b0;
            end
            if (done[k]) begin
                if (sb.size() == 0 || sb[0].dut != k) begin
                    chk($sformatf("unexpected_done_dut%0d", k), 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("word_dut%0d", k), int'(ds_do[k]), int'(e.word));
                    chk($sformatf("sclk_rises_dut%0d", k), rises[k], W);
                    chk($sformatf("xfer_len_dut%0d", k), cyc - acc[k], xfer_cycles(W, div));
                    chk($sformatf("edge_timing_dut%0d", k), int'(tim_bad[k]), 0);
                    chk($sformatf("ready_low_busy_dut%0d", k), int'(rdy_bad[k]), 0);
                    chk($sformatf("done_single_dut%0d", k), int'(prev_done[k]), 0);
                end
                done_cnt[k]++;
                last_done[k] = cyc;
                busy[k]      = 1'b0;
            end else if (busy[k] && in_ready[k]) begin
                rdy_bad[k] = 1'b1;
            end
            if (!reset && in_valid[k] && in_ready[k]) begin
                acc[k]      = cyc + 1;
                last_gap[k] = acc[k] - last_done[k];
                rises[k]    = 0;
                tim_bad[k]  = 1'b0;
                rdy_bad[k]  = 1'b0;
                busy[k]     = 1'b1;
            end
            prev_sclk[k]  = sclk[k];
            prev_latch[k] = latch[k];
            prev_done[k]  = done[k];
        end
    end

    task automatic send(input int k, input logic [W-1:0] w, input bit push);
        @(posedge clk) #2;
        in_data[k]  = w;
        in_valid[k] = 1'b1;
        if (push) sb.push_back('{dut: k, word: w});
        @(posedge clk) #2;
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int start = done_cnt[k];
        int n     = 0;
        while (done_cnt[k] == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk($sformatf("done_seen_dut%0d", k), done_cnt[k] - start, 1);
    endtask

    initial begin : stimulus
        int r;
        in_valid = '{1'b0, 1'b0};
        in_data  = '{default: '0};
        for (int k = 0; k < 2; k++) begin
            ds_sr[k] = '0;
            ds_do[k] = '0;
        end

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_sclk", int'(sclk[0]), 0);
        chk("rst_sdata", int'(sdata[0]), 0);
        chk("rst_latch", int'(latch[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        chk("rst_sr_reset", int'(sr_reset[0]), 1);
        chk("rst_in_ready", int'(in_ready[0]), 1);
        reset = 1'b0;
        #1;
        chk("sr_reset_held_until_edge", int'(sr_reset[0]), 1);
        @(posedge clk) #1;
        chk("sr_reset_released_a", int'(sr_reset[0]), 0);
        chk("sr_reset_released_b", int'(sr_reset[1]), 0);
        chk("ready_after_release", int'(in_ready[0]), 1);

        // Single word
        send(0, 8'hA5, 1'b1);
        wait_done(0, 100);

        // Back-to-back with in_valid held
        @(posedge clk) #2;
        in_data[0]  = 8'h3C;
        in_valid[0] = 1'b1;
        sb.push_back('{dut: 0, word: 8'h3C});
        @(posedge clk) #2;
        in_data[0] = 8'hC3;
        sb.push_back('{dut: 0, word: 8'hC3});
        wait_done(0, 100);
        @(posedge clk) #2;
        in_valid[0] = 1'b0;
        wait_done(0, 100);
        chk("b2b_gap", last_gap[0], 1);

        // in_data changes while busy
        send(0, 8'h00, 1'b1);
        repeat (10) @(posedge clk);
        #2;
        in_data[0] = 8'hFF;
        wait_done(0, 100);

        // Reset at edge 15 of a transfer
        send(0, 8'hFF, 1'b0);
        repeat (14) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_sclk", int'(sclk[0]), 0);
        chk("midrst_sdata", int'(sdata[0]), 0);
        chk("midrst_latch", int'(latch[0]), 0);
        chk("midrst_sr_reset", int'(sr_reset[0]), 1);
        chk("midrst_in_ready", int'(in_ready[0]), 1);
        r = rises[0];
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("midrst_no_more_rises", rises[0], r);
        chk("midrst_ds_cleared", int'(ds_do[0]), 0);
        chk("midrst_done_count", done_cnt[0], 4);
        send(0, 8'h81, 1'b1);
        wait_done(0, 100);

        // CLK_DIV = 1
        send(1, 8'h01, 1'b1);
        wait_done(1, 60);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
